// File: rtl/shift_pkg.sv
// Shared encodings and default sizes for the shift sequencer and its shifter.
package shift_pkg;

    localparam int WIDTH = 16;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_ROR  = 2'b01,
        OP_ASR  = 2'b10,
        OP_RRC  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/shift_count.sv
// Loadable down-counter holding the remaining number of single-bit steps.
module shift_count #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic             is_one,
    output logic             is_zero
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Decrement saturates at zero so the count can never wrap.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign is_one  = (count_q == CNT_W'(1));
    assign is_zero = (count_q == '0);

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle controller that iterates an external single-step shifter
// once per cycle for a programmable number of steps.
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int WIDTH = shift_pkg::WIDTH,
    parameter int CNT_W = shift_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [CNT_W-1:0] amount,
    input  logic [WIDTH-1:0] A,
    input  logic             C_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Y,
    output logic             C_out,
    output logic [WIDTH-1:0] sh_A,
    output logic [1:0]       sh_op,
    output logic             sh_C_in,
    input  logic [WIDTH-1:0] sh_Y,
    input  logic             sh_C_out
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic             carry_q, carry_d;
    logic [1:0]       op_q, op_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             c_out_q, c_out_d;
    logic             cnt_load, cnt_dec, cnt_is_one, cnt_is_zero;

    shift_count #(.CNT_W(CNT_W)) u_count (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (amount),
        .is_one   (cnt_is_one),
        .is_zero  (cnt_is_zero)
    );

    // Y/C_out are captured on the edge entering DONE, so the result is
    // taken straight from the shifter on the final step.
    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        carry_d  = carry_q;
        op_d     = op_q;
        y_d      = y_q;
        c_out_d  = c_out_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cnt_load = 1'b1;
                    work_d   = A;
                    carry_d  = C_in;
                    op_d     = op;
                    if ((amount == '0) || (op == OP_NONE)) begin
                        state_d = ST_DONE;
                        y_d     = A;
                        c_out_d = C_in;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                work_d  = sh_Y;
                carry_d = sh_C_out;
                cnt_dec = 1'b1;
                if (cnt_is_one || cnt_is_zero) begin
                    state_d = ST_DONE;
                    y_d     = sh_Y;
                    c_out_d = sh_C_out;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_SHIFT);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            work_q  <= '0;
            carry_q <= 1'b0;
            op_q    <= 2'b00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            y_q     <= '0;
            c_out_q <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            carry_q <= carry_d;
            op_q    <= op_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            y_q     <= y_d;
            c_out_q <= c_out_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign Y       = y_q;
    assign C_out   = c_out_q;
    assign sh_A    = work_q;
    assign sh_op   = op_q;
    assign sh_C_in = carry_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with a behavioural single-step shifter attached.
module tb_shift_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [3:0]  amount = 4'd0;
    logic [15:0] A = 16'h0000;
    logic        C_in = 1'b0;
    logic        busy, done, C_out, sh_C_in, sh_C_out;
    logic [15:0] Y, sh_A, sh_Y;
    logic [1:0]  sh_op;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shift_sequencer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .amount   (amount),
        .A        (A),
        .C_in     (C_in),
        .busy     (busy),
        .done     (done),
        .Y        (Y),
        .C_out    (C_out),
        .sh_A     (sh_A),
        .sh_op    (sh_op),
        .sh_C_in  (sh_C_in),
        .sh_Y     (sh_Y),
        .sh_C_out (sh_C_out)
    );

    // Single-step shifter as the parent would provide it
    always_comb begin
        sh_Y     = sh_A;
        sh_C_out = sh_C_in;
        case (sh_op)
            2'b01:   sh_Y = {sh_A[0], sh_A[15:1]};
            2'b10:   sh_Y = {sh_A[15], sh_A[15:1]};
            2'b11: begin
                sh_Y     = {sh_C_in, sh_A[15:1]};
                sh_C_out = sh_A[0];
            end
            default: sh_Y = sh_A;
        endcase
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one start, then measure latency and busy cycles and check the result
    task automatic applyStimulus(input string tag, input logic [1:0] o, input logic [3:0] amt,
                                 input logic [15:0] a, input logic c, input logic [15:0] expY,
                                 input logic expC, input int expLat, input int expBusy);
        int lat;
        int busyCnt;
        lat = 0;
        busyCnt = 0;
        @(negedge clk);
        op = o; amount = amt; A = a; C_in = c; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        op = 2'b00; amount = 4'd0; A = 16'h5A5A; C_in = ~c;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (busy) busyCnt++;
            if (done) begin
                lat = k;
                break;
            end
        end
        checkOutput({tag, "_latency"}, lat, expLat);
        checkOutput({tag, "_busy_cycles"}, busyCnt, expBusy);
        checkOutput({tag, "_Y"}, Y, expY);
        checkOutput({tag, "_C_out"}, C_out, expC);
        @(negedge clk);
        checkOutput({tag, "_done_pulse"}, done, 1'b0);
        checkOutput({tag, "_Y_hold"}, Y, expY);
    endtask

    initial begin
        int seen;
        #12;
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_Y", Y, 16'h0000);
        checkOutput("rst_C_out", C_out, 1'b0);
        checkOutput("rst_sh_A", sh_A, 16'h0000);
        checkOutput("rst_sh_op", sh_op, 2'b00);
        checkOutput("rst_sh_C_in", sh_C_in, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus("asr3", 2'b10, 4'd3, 16'h8000, 1'b1, 16'hF000, 1'b1, 4, 3);
        applyStimulus("ror4", 2'b01, 4'd4, 16'h0001, 1'b0, 16'h1000, 1'b0, 5, 4);
        applyStimulus("ror15", 2'b01, 4'd15, 16'h0001, 1'b0, 16'h0002, 1'b0, 16, 15);
        applyStimulus("rrc1", 2'b11, 4'd1, 16'h0001, 1'b0, 16'h0000, 1'b1, 2, 1);
        applyStimulus("rrc2", 2'b11, 4'd2, 16'h0001, 1'b0, 16'h8000, 1'b0, 3, 2);
        applyStimulus("amt0", 2'b10, 4'd0, 16'h1234, 1'b1, 16'h1234, 1'b1, 1, 0);
        applyStimulus("opnone", 2'b00, 4'd5, 16'hABCD, 1'b0, 16'hABCD, 1'b0, 1, 0);

        // start while busy must be ignored
        @(negedge clk);
        op = 2'b01; amount = 4'd4; A = 16'h0001; C_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("busy_sh_op", sh_op, 2'b01);
        @(negedge clk);
        op = 2'b10; amount = 4'd1; A = 16'hFFFF; C_in = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done) seen++;
        end
        checkOutput("ignore_done_count", seen, 1);
        checkOutput("ignore_Y", Y, 16'h1000);
        checkOutput("ignore_C_out", C_out, 1'b0);

        // reset in the middle of a long shift
        @(negedge clk);
        op = 2'b01; amount = 4'd10; A = 16'h0003; C_in = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("pre_rst_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_busy", busy, 1'b0);
        checkOutput("midrst_done", done, 1'b0);
        checkOutput("midrst_Y", Y, 16'h0000);
        checkOutput("midrst_C_out", C_out, 1'b0);
        checkOutput("midrst_sh_A", sh_A, 16'h0000);
        checkOutput("midrst_sh_op", sh_op, 2'b00);
        checkOutput("midrst_sh_C_in", sh_C_in, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        checkOutput("post_rst_quiet", seen, 0);

        applyStimulus("after_rst", 2'b10, 4'd3, 16'h8000, 1'b1, 16'hF000, 1'b1, 4, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
